seg_scan_ctrl: RTL and testbench

//  Parametrised multiplexed 7-segment scanner: NUM_DIGITS hex digits plus decimal points,
//  per-digit enable, 16-level PWM brightness, anti-ghost dead time between digits.

---
 rtl/seg_scan_ctrl_pkg.sv | 14 +
 rtl/seg_scan_ctrl_hex_decode.sv | 15 +
 rtl/seg_scan_ctrl.sv | 89 ++++++++
 tb/tb_seg_scan_ctrl.sv | 112 +++++++++++
 4 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// seg_scan_ctrl_pkg: shared segment constants and the active-high hex-to-segment table
// Exports SEG_A/SEG_DP bit positions, SEG_OFF (all segments dark, active-high) and hex_seg().
package seg_scan_ctrl_pkg;
  localparam int SEG_A = 0;
  localparam int SEG_DP = 7;
  localparam logic [7:0] SEG_OFF = 8'h00;
  localparam logic [6:0] HEX_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    return HEX_LUT[n];
  endfunction
endpackage

// File: rtl/seg_scan_ctrl_hex_decode.sv
// seg_hex_decode: nibble + decimal point to active-high {dp,g,f,e,d,c,b,a}
// Ports: nibble (4-bit value), dp (1 = point lit), seg (active-high segment pattern).
module seg_hex_decode
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);
  always_comb begin
    seg = SEG_OFF;
    seg[SEG_DP-1:SEG_A] = hex_seg(nibble);
    seg[SEG_DP] = dp;
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment scanner with per-frame input latch, PWM and dead time
// Ports: clk, reset_n (async active-low); disp_data/dp/digit_en/brightness in;
//        sel (one-hot digit select), seg ({dp,g..a}), frame_start (latch pulse) out, all registered.
// Option: define SEG_LZ_BLANK_EN for leading-zero suppression on the latched data.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 50_000_000,
  parameter int SCAN_HZ      = 1000,
  parameter int NUM_DIGITS   = 8,
  parameter int BLANK_CYCLES = 500,
  parameter int SEG_ACT_LOW  = 1,
  parameter int SEL_ACT_LOW  = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] disp_data,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [3:0]              brightness,
  output logic [NUM_DIGITS-1:0]   sel,
  output logic [7:0]              seg,
  output logic                    frame_start
);
  localparam int TICK_DIV = CLK_FREQ_HZ / SCAN_HZ;
  localparam int SW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int DW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(TICK_DIV - 1);
  localparam logic [SW-1:0] BLANK_L = SW'(BLANK_CYCLES);
  localparam logic [DW-1:0] DIG_LAST = DW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_XOR = (SEL_ACT_LOW != 0) ? '1 : '0;
  localparam logic [7:0] SEG_XOR = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
  logic [SW-1:0] slot_cnt;
  logic [DW-1:0] dig_idx;
  logic [3:0] pwm_cnt, bright_l, bright_e;
  logic [4*NUM_DIGITS-1:0] data_l, data_e;
  logic [NUM_DIGITS-1:0] dp_l, dp_e, en_l, en_e, sel_hi;
  logic [7:0] dec_seg, seg_hi;
  logic fs, show, lit;
  // the latch cycle already displays the freshly sampled inputs, so a zero dead time never shows stale data
  always_comb begin
    fs = slot_cnt == '0 && dig_idx == '0;
    data_e = fs ? disp_data : data_l;
    dp_e = fs ? dp : dp_l;
    en_e = fs ? digit_en : en_l;
    bright_e = fs ? brightness : bright_l;
`ifdef SEG_LZ_BLANK_EN
    show = dig_idx == '0 || dp_e[dig_idx] || |(data_e >> (4 * dig_idx));
`else
    show = 1'b1;
`endif
    lit = slot_cnt >= BLANK_L && pwm_cnt <= bright_e && en_e[dig_idx] && show;
    sel_hi = lit ? NUM_DIGITS'(1) << dig_idx : '0;
    seg_hi = lit ? dec_seg : SEG_OFF;
  end
  seg_hex_decode u_dec (
    .nibble(data_e[4*dig_idx +: 4]),
    .dp    (dp_e[dig_idx]),
    .seg   (dec_seg)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_cnt <= '0;
      dig_idx <= '0;
      pwm_cnt <= '0;
      data_l <= '0;
      dp_l <= '0;
      en_l <= '0;
      bright_l <= '0;
      sel <= SEL_XOR;
      seg <= SEG_OFF ^ SEG_XOR;
      frame_start <= 1'b0;
    end else begin
      slot_cnt <= slot_cnt == SLOT_LAST ? '0 : slot_cnt + SW'(1);
      if (slot_cnt == SLOT_LAST) dig_idx <= dig_idx == DIG_LAST ? '0 : dig_idx + DW'(1);
      // pwm_cnt reads 0 in the first cycle after the dead time of every slot
      pwm_cnt <= (slot_cnt < BLANK_L || slot_cnt == SLOT_LAST) ? '0 : pwm_cnt + 4'd1;
      if (fs) begin
        data_l <= disp_data;
        dp_l <= dp;
        en_l <= digit_en;
        bright_l <= brightness;
      end
      sel <= sel_hi ^ SEL_XOR;
      seg <= seg_hi ^ SEG_XOR;
      frame_start <= fs;
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: table-driven frame checks of seg_scan_ctrl (TICK_DIV=10, 2 dead clk, 8 digits)
module tb_seg_scan_ctrl;
  typedef struct {
    logic [31:0] data;
    logic [31:0] mid;
    logic [7:0]  dp;
    logic [7:0]  en;
    logic [3:0]  br;
    logic [63:0] exp;
    int          lit_n;
  } vec_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [31:0] disp_data = '0;
  logic [7:0] dp = '0, digit_en = '0;
  logic [3:0] brightness = '0;
  logic [7:0] sel, seg;
  logic frame_start;
  int n_chk = 0, n_fail = 0;
  vec_t vecs [10];
  seg_scan_ctrl #(
    .CLK_FREQ_HZ(1000), .SCAN_HZ(100), .NUM_DIGITS(8),
    .BLANK_CYCLES(2), .SEG_ACT_LOW(1), .SEL_ACT_LOW(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .disp_data(disp_data), .dp(dp),
    .digit_en(digit_en), .brightness(brightness),
    .sel(sel), .seg(seg), .frame_start(frame_start)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic [31:0] data, input logic [31:0] mid, input logic [7:0] dpv,
                              input logic [7:0] en, input logic [3:0] br, input logic [63:0] exp,
                              input int lit_n);
    vec_t v;
    v.data = data; v.mid = mid; v.dp = dpv; v.en = en; v.br = br; v.exp = exp; v.lit_n = lit_n;
    return v;
  endfunction
  task automatic run_frame(input vec_t v, input int vi);
    int w;
    int d, s;
    logic [7:0] e;
    logic [15:0] exp16;
    disp_data = v.data; dp = v.dp; digit_en = v.en; brightness = v.br;
    w = 0;
    do begin
      @(posedge clk); #1;
      w++;
    end while (frame_start !== 1'b1 && w < 200);
    chk($sformatf("v%0d_frame_start_wait", vi), 32'(frame_start), 32'd1);
    if (frame_start !== 1'b1) return;
    for (int c = 0; c < 80; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        chk($sformatf("v%0d_c%0d_frame_start_low", vi, c), 32'(frame_start), 32'd0);
      end
      d = c / 10;
      s = c % 10;
      e = v.exp[8*d +: 8];
      exp16 = (s >= 2 && s - 2 < v.lit_n && e != 8'hFF) ? {8'(1 << d), e} : 16'h00FF;
      chk($sformatf("v%0d_c%0d_sel_seg", vi, c), 32'({sel, seg}), 32'(exp16));
      if (c == 40) disp_data = v.mid;
    end
  endtask
  initial begin
    vecs[0] = mk(32'h12345678, 32'h12345678, 8'h00, 8'hFF, 4'd15, 64'hF9A4B0999282F880, 8);
    vecs[1] = mk(32'h12345678, 32'h12345678, 8'h00, 8'hFF, 4'd3, 64'hF9A4B0999282F880, 4);
    vecs[2] = mk(32'h9ABCDEF0, 32'h00000000, 8'h00, 8'hFF, 4'd15, 64'h908883C6A1868EC0, 8);
`ifdef SEG_LZ_BLANK_EN
    vecs[3] = mk(32'h00000000, 32'h00000000, 8'h00, 8'hFF, 4'd15, 64'hFFFFFFFFFFFFFFC0, 8);
    vecs[7] = mk(32'h00000050, 32'h00000050, 8'h00, 8'hFF, 4'd15, 64'hFFFFFFFFFFFF92C0, 8);
    vecs[8] = mk(32'h00000050, 32'h00000050, 8'h08, 8'hFF, 4'd15, 64'hFFFFFFFF40FF92C0, 8);
`else
    vecs[3] = mk(32'h00000000, 32'h00000000, 8'h00, 8'hFF, 4'd15, 64'hC0C0C0C0C0C0C0C0, 8);
    vecs[7] = mk(32'h00000050, 32'h00000050, 8'h00, 8'hFF, 4'd15, 64'hC0C0C0C0C0C092C0, 8);
    vecs[8] = mk(32'h00000050, 32'h00000050, 8'h08, 8'hFF, 4'd15, 64'hC0C0C0C040C092C0, 8);
`endif
    vecs[4] = mk(32'h12345678, 32'h12345678, 8'h01, 8'hFE, 4'd15, 64'hF9A4B0999282F8FF, 8);
    vecs[5] = mk(32'h12345678, 32'h12345678, 8'h80, 8'hFF, 4'd0, 64'h79A4B0999282F880, 1);
    vecs[6] = mk(32'h12345678, 32'h12345678, 8'h00, 8'h00, 4'd15, 64'hFFFFFFFFFFFFFFFF, 8);
    vecs[9] = mk(32'hFFFFFFFF, 32'hFFFFFFFF, 8'h00, 8'hFF, 4'd7, 64'h8E8E8E8E8E8E8E8E, 8);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_sel", 32'(sel), 32'h00);
    chk("reset_seg", 32'(seg), 32'hFF);
    chk("reset_frame_start", 32'(frame_start), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < 10; i++) run_frame(vecs[i], i);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("async_reset_sel_seg", 32'({sel, seg}), 32'h00FF);
    chk("async_reset_frame_start", 32'(frame_start), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rerelease_frame_start", 32'(frame_start), 32'd1);
    chk("rerelease_dead", 32'({sel, seg}), 32'h00FF);
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk); #1;
      if (c == 2) chk("rerelease_digit0_lit", 32'({sel, seg}), 32'h018E);
      if (c == 79) chk("rerelease_frame_start_low", 32'(frame_start), 32'd0);
      if (c == 80) chk("rerelease_frame_period", 32'(frame_start), 32'd1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
